// File: rtl/scsi_dma_target_pkg.sv
// -----------------------------------------------------------------------------
// scsi_dma_target_pkg
// Shared definitions for the SCSI controller responder model:
//   - register addresses reached through the AR/data register pair
//   - CTRL and STATUS bit positions
//   - DMA state machine encoding
//   - address-register increment helper (5-bit wrap)
// -----------------------------------------------------------------------------
package scsi_dma_target_pkg;

    localparam logic [4:0] REG_CTRL   = 5'h01;
    localparam logic [4:0] REG_TC_HI  = 5'h12;
    localparam logic [4:0] REG_TC_LO  = 5'h13;
    localparam logic [4:0] REG_STATUS = 5'h17;

    localparam int CTRL_DMA_EN_BIT = 0;
    localparam int CTRL_DIR_BIT    = 1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } dma_state_e;

    // AR is 5 bits wide, so 0x1F rolls over to 0x00.
    function automatic logic [4:0] ar_next(input logic [4:0] a);
        return a + 5'd1;
    endfunction

endpackage

// File: rtl/scsi_dma_target_if.sv
// -----------------------------------------------------------------------------
// scsi_dma_target_if
// Host bus (chip select, RE/WE, DREQ_/DACK) and phase-side FIFO port of the
// SCSI controller responder.
//   master : host / phase-side driver (SDMAC side, or a testbench)
//   slave  : the controller model (scsi_dma_target)
// -----------------------------------------------------------------------------
interface scsi_dma_target_if;
    import scsi_dma_target_pkg::*;

    logic       SCSI_CS_;
    logic       A0;
    logic       RE;
    logic       WE;
    logic       DACK;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic       DREQ_;
    logic       INTRQ;
    logic [7:0] PH_WDATA;
    logic       PH_WVALID;
    logic       PH_WREADY;
    logic [7:0] PH_RDATA;
    logic       PH_RVALID;
    logic       PH_RREADY;

    modport master (
        output SCSI_CS_, A0, RE, WE, DACK, DIN, PH_WDATA, PH_WVALID, PH_RREADY,
        input  DOUT, DOE, DREQ_, INTRQ, PH_WREADY, PH_RDATA, PH_RVALID
    );

    modport slave (
        input  SCSI_CS_, A0, RE, WE, DACK, DIN, PH_WDATA, PH_WVALID, PH_RREADY,
        output DOUT, DOE, DREQ_, INTRQ, PH_WREADY, PH_RDATA, PH_RVALID
    );

endinterface

// File: rtl/scsi_byte_fifo.sv
// -----------------------------------------------------------------------------
// scsi_byte_fifo
// Byte FIFO between the DMA engine and the phase-side port.
//   CPUCLK, RESET : clock, asynchronous active-high reset (discards contents)
//   push, wdata   : write request and byte
//   pop, rdata    : read request and head byte (rdata is the current head)
//   full, empty   : occupancy flags
// A push on a full FIFO is accepted when a legal pop happens in the same
// cycle; illegal pushes and pops are silently dropped.
// -----------------------------------------------------------------------------
module scsi_byte_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CPUCLK,
    input  logic       RESET,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries data only; pointers alone define the valid contents.
    always_ff @(posedge CPUCLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/scsi_dma_target.sv
// -----------------------------------------------------------------------------
// scsi_dma_target
// Controller-side responder for the SDMAC host interface.
//   CPUCLK : sole clock, all inputs sampled on the rising edge
//   RESET  : asynchronous active-high reset
//   bus    : host register port (SCSI_CS_/A0/RE/WE/DIN/DOUT/DOE), DMA
//            handshake (DREQ_/DACK), INTRQ, and the phase-side FIFO port
// Registers are reached indirectly: A0=0 addresses AR, A0=1 the register AR
// points at (AR auto-increments). The DMA engine moves one byte per
// DREQ_/DACK beat between the host and the FIFO, counting down TC.
// -----------------------------------------------------------------------------
module scsi_dma_target
    import scsi_dma_target_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TC_W       = 16
) (
    input  logic             CPUCLK,
    input  logic             RESET,
    scsi_dma_target_if.slave bus
);
    dma_state_e      state;
    logic [4:0]      ar;
    logic            dma_en, dir, done_f, err_f;
    logic [TC_W-1:0] tc;
    logic [15:0]     tc16;
    logic            re_q, we_q;
    logic            rd_act, rd_a0;
    logic            xfer_dir;
    logic [7:0]      wr_byte;
    logic [7:0]      dout_r;
    logic            doe_r, dreq_n, intrq_r;
    logic [7:0]      rd_val;
    logic            busy, data_ok, reg_sel;
    logic            re_edge, we_edge, beat_start, bad_strobe;
    logic            dma_push, dma_pop;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_head;

    assign tc16       = 16'(tc);
    assign busy       = (state != ST_IDLE);
    assign re_edge    = bus.RE && !re_q;
    assign we_edge    = bus.WE && !we_q;
    assign reg_sel    = !bus.SCSI_CS_ && !bus.DACK;
    assign data_ok    = dir ? !fifo_empty : !fifo_full;
    assign beat_start = bus.DACK && (dir ? re_edge : we_edge);
    assign bad_strobe = bus.DACK && (dir ? we_edge : re_edge);

    // The FIFO side of a beat happens on the cycle the host strobe ends.
    assign dma_pop  = (state == ST_XFER) &&  xfer_dir && !bus.RE;
    assign dma_push = (state == ST_XFER) && !xfer_dir && !bus.WE;

    scsi_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CPUCLK (CPUCLK),
        .RESET  (RESET),
        .push   (dma_push || bus.PH_WVALID),
        .wdata  (dma_push ? wr_byte : bus.PH_WDATA),
        .pop    (dma_pop || bus.PH_RREADY),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A DMA push owns the FIFO write port that cycle.
    assign bus.PH_WREADY = !fifo_full && !dma_push;
    assign bus.PH_RDATA  = fifo_head;
    assign bus.PH_RVALID = !fifo_empty;
    assign bus.DOUT      = dout_r;
    assign bus.DOE       = doe_r;
    assign bus.DREQ_     = dreq_n;
    assign bus.INTRQ     = intrq_r;

    always_comb begin
        rd_val = 8'h00;
        case (ar)
            REG_CTRL:   rd_val = {6'b0, dir, dma_en};
            REG_TC_HI:  rd_val = tc16[15:8];
            REG_TC_LO:  rd_val = tc16[7:0];
            REG_STATUS: rd_val = {5'b0, err_f, done_f, busy};
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge CPUCLK) begin
        if (state == ST_REQ && beat_start) wr_byte <= bus.DIN;
    end

    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            ar       <= '0;
            dma_en   <= 1'b0;
            dir      <= 1'b0;
            done_f   <= 1'b0;
            err_f    <= 1'b0;
            tc       <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            rd_act   <= 1'b0;
            rd_a0    <= 1'b0;
            xfer_dir <= 1'b0;
            dout_r   <= 8'h00;
            doe_r    <= 1'b0;
            dreq_n   <= 1'b1;
            intrq_r  <= 1'b0;
        end else begin
            re_q <= bus.RE;
            we_q <= bus.WE;

            // Register writes
            if (reg_sel && we_edge) begin
                if (!bus.A0) begin
                    ar <= bus.DIN[4:0];
                end else begin
                    ar <= ar_next(ar);
                    case (ar)
                        REG_CTRL: begin
                            dma_en <= bus.DIN[CTRL_DMA_EN_BIT];
                            dir    <= bus.DIN[CTRL_DIR_BIT];
                        end
                        REG_TC_HI: if (!busy) tc <= TC_W'({bus.DIN, tc16[7:0]});
                        REG_TC_LO: if (!busy) tc <= TC_W'({tc16[15:8], bus.DIN});
                        default: ;
                    endcase
                end
            end

            // Register reads: DOUT tracks the live value while RE is held;
            // side effects (AR increment, STATUS clear) land when RE drops.
            if (reg_sel && re_edge) begin
                rd_act <= 1'b1;
                rd_a0  <= bus.A0;
                doe_r  <= 1'b1;
                dout_r <= bus.A0 ? rd_val : {3'b0, ar};
            end else if (rd_act && bus.RE) begin
                dout_r <= rd_a0 ? rd_val : {3'b0, ar};
            end else if (rd_act) begin
                rd_act <= 1'b0;
                doe_r  <= 1'b0;
                dout_r <= 8'h00;
                if (rd_a0) begin
                    ar <= ar_next(ar);
                    if (ar == REG_STATUS) begin
                        done_f  <= 1'b0;
                        err_f   <= 1'b0;
                        intrq_r <= 1'b0;
                    end
                end
            end

            // Protocol violations
            if (!bus.SCSI_CS_ && bus.DACK) err_f <= 1'b1;
            if (bus.DACK && (state == ST_IDLE || state == ST_RELEASE)) err_f <= 1'b1;

            // DMA engine
            case (state)
                ST_IDLE: begin
                    if (dma_en && tc != '0 && data_ok) begin
                        state  <= ST_REQ;
                        dreq_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!dma_en) begin
                        state  <= ST_IDLE;
                        dreq_n <= 1'b1;
                    end else if (beat_start) begin
                        state    <= ST_XFER;
                        xfer_dir <= dir;
                        if (dir) begin
                            dout_r <= fifo_head;
                            doe_r  <= 1'b1;
                        end
                    end else if (bad_strobe) begin
                        err_f <= 1'b1;
                    end
                end
                ST_XFER: begin
                    // DMA_EN is not checked here so a started beat always completes.
                    if (xfer_dir ? !bus.RE : !bus.WE) begin
                        state  <= ST_RELEASE;
                        tc     <= tc - TC_W'(1);
                        dreq_n <= 1'b1;
                        if (xfer_dir) begin
                            doe_r  <= 1'b0;
                            dout_r <= 8'h00;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tc == '0) begin
                        state <= ST_DONE;
                    end else if (dma_en && data_ok) begin
                        state  <= ST_REQ;
                        dreq_n <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done_f  <= 1'b1;
                    intrq_r <= 1'b1;
                    dma_en  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scsi_dma_target.sv
// -----------------------------------------------------------------------------
// tb_scsi_dma_target
// Directed sequence with random payload bytes; expectations come from a
// queue model of the FIFO and from the register/transfer rules.
// -----------------------------------------------------------------------------
module tb_scsi_dma_target;
    logic CPUCLK;
    logic RESET;
    int   tests = 0;
    int   fails = 0;

    scsi_dma_target_if bus ();

    scsi_dma_target #(.FIFO_DEPTH(8), .TC_W(16)) dut (
        .CPUCLK (CPUCLK),
        .RESET  (RESET),
        .bus    (bus.slave)
    );

    initial CPUCLK = 1'b0;
    always #5 CPUCLK = ~CPUCLK;

    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CPUCLK);
    endtask

    task automatic bus_wr(input logic a0, input logic [7:0] d);
        bus.SCSI_CS_ = 1'b0; bus.A0 = a0; bus.DIN = d; bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        tick();
        bus.SCSI_CS_ = 1'b1;
        tick();
    endtask

    task automatic bus_rd(input logic a0, output logic [7:0] d, output logic oe);
        bus.SCSI_CS_ = 1'b0; bus.A0 = a0; bus.RE = 1'b1;
        tick();
        tick();
        d  = bus.DOUT;
        oe = bus.DOE;
        bus.RE = 1'b0;
        tick();
        bus.SCSI_CS_ = 1'b1;
        tick();
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
        bus_wr(1'b0, {3'b0, a});
        bus_wr(1'b1, d);
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [7:0] d);
        logic oe;
        bus_wr(1'b0, {3'b0, a});
        bus_rd(1'b1, d, oe);
    endtask

    task automatic ph_push(input logic [7:0] d);
        bus.PH_WVALID = 1'b1; bus.PH_WDATA = d;
        tick();
        bus.PH_WVALID = 1'b0;
        q.push_back(d);
    endtask

    task automatic ph_pop(input string tag);
        logic [7:0] e;
        e = q.pop_front();
        chk(tag, bus.PH_RDATA, e);
        bus.PH_RREADY = 1'b1;
        tick();
        bus.PH_RREADY = 1'b0;
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (bus.DREQ_ !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, bus.DREQ_}, 32'd0);
    endtask

    task automatic beat_rd(output logic [7:0] d, output logic oe);
        bus.DACK = 1'b1; bus.RE = 1'b1;
        tick();
        tick();
        d  = bus.DOUT;
        oe = bus.DOE;
        bus.RE = 1'b0; bus.DACK = 1'b0;
        tick();
    endtask

    task automatic beat_wr(input logic [7:0] d);
        bus.DACK = 1'b1; bus.WE = 1'b1; bus.DIN = d;
        tick();
        bus.WE = 1'b0; bus.DACK = 1'b0;
        tick();
        q.push_back(d);
    endtask

    task automatic set_tc(input logic [15:0] v);
        reg_wr(5'h12, v[15:8]);
        bus_wr(1'b1, v[7:0]);
    endtask

    task automatic hold_high(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.DREQ_ !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        logic [7:0] d, e;
        logic       oe;
        logic [15:0] v;

        RESET = 1'b1;
        bus.SCSI_CS_ = 1'b1; bus.A0 = 1'b0; bus.RE = 1'b0; bus.WE = 1'b0;
        bus.DACK = 1'b0; bus.DIN = 8'h00; bus.PH_WDATA = 8'h00;
        bus.PH_WVALID = 1'b0; bus.PH_RREADY = 1'b0;
        tick(); tick();

        // ---- reset state
        chk("rst_dout",  bus.DOUT, 0);
        chk("rst_doe",   bus.DOE, 0);
        chk("rst_dreq",  bus.DREQ_, 1);
        chk("rst_intrq", bus.INTRQ, 0);
        chk("rst_rvalid", bus.PH_RVALID, 0);
        chk("rst_wready", bus.PH_WREADY, 1);
        RESET = 1'b0;
        tick();

        // ---- register round trip
        bus_wr(1'b0, 8'h12);
        bus_wr(1'b1, 8'hAB);
        bus_wr(1'b1, 8'hCD);
        bus_wr(1'b0, 8'h12);
        bus_rd(1'b1, d, oe);
        chk("rt_hi", d, 8'hAB);
        chk("rt_doe", oe, 1);
        bus_rd(1'b1, d, oe);
        chk("rt_lo", d, 8'hCD);
        bus_rd(1'b0, d, oe);
        chk("rt_ar", d, 8'h14);
        chk("rt_doe_off", bus.DOE, 0);
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            set_tc(v);
            reg_rd(5'h12, d); chk("rnd_tc_hi", d, v[15:8]);
            reg_rd(5'h13, d); chk("rnd_tc_lo", d, v[7:0]);
        end
        reg_rd(5'h05, d); chk("unmapped", d, 0);

        // ---- DMA read (FIFO to host)
        for (int i = 0; i < 3; i++) ph_push(8'($urandom));
        set_tc(16'd3);
        reg_wr(5'h01, 8'h03);
        for (int i = 0; i < 3; i++) begin
            wait_dreq("rd_dreq");
            e = q.pop_front();
            beat_rd(d, oe);
            chk("rd_data", d, e);
            chk("rd_doe", oe, 1);
            chk("rd_gap", bus.DREQ_, 1);
        end
        tick(); tick(); tick();
        chk("rd_intrq", bus.INTRQ, 1);
        chk("rd_fifo_empty", bus.PH_RVALID, 0);
        reg_rd(5'h17, d); chk("rd_status", d, 8'h02);
        chk("rd_intrq_clr", bus.INTRQ, 0);
        reg_rd(5'h01, d); chk("rd_ctrl", d, 8'h02);

        // ---- DMA write with backpressure
        set_tc(16'd10);
        reg_wr(5'h01, 8'h01);
        for (int i = 0; i < 8; i++) begin
            wait_dreq("wr_dreq");
            beat_wr(8'($urandom));
        end
        hold_high("wr_full_hold", 6);
        chk("wr_wready_full", bus.PH_WREADY, 0);
        ph_pop("wr_pop_first");
        wait_dreq("wr_dreq9");
        beat_wr(8'($urandom));
        hold_high("wr_full_hold2", 6);
        reg_rd(5'h13, d); chk("wr_tc_left", d, 1);
        for (int i = 0; i < 8; i++) ph_pop("wr_drain");
        wait_dreq("wr_dreq10");
        beat_wr(8'($urandom));
        tick(); tick(); tick();
        chk("wr_intrq", bus.INTRQ, 1);
        ph_pop("wr_last");
        chk("wr_empty", bus.PH_RVALID, 0);
        reg_rd(5'h17, d); chk("wr_status", d, 8'h02);

        // ---- protocol violations
        bus.DACK = 1'b1; tick(); bus.DACK = 1'b0; tick();
        chk("idle_dack_fifo", bus.PH_RVALID, 0);
        reg_rd(5'h17, d); chk("idle_dack_err", d, 8'h04);
        reg_rd(5'h17, d); chk("err_cleared", d, 8'h00);

        ph_push(8'($urandom));
        set_tc(16'd1);
        reg_wr(5'h01, 8'h03);
        wait_dreq("cs_dreq");
        e = q.pop_front();
        bus.SCSI_CS_ = 1'b0; bus.A0 = 1'b1;
        bus.DACK = 1'b1; bus.RE = 1'b1;
        tick(); tick();
        chk("cs_beat_data", bus.DOUT, e);
        bus.RE = 1'b0; bus.DACK = 1'b0; bus.SCSI_CS_ = 1'b1;
        tick(); tick(); tick(); tick();
        chk("cs_intrq", bus.INTRQ, 1);
        chk("cs_fifo_empty", bus.PH_RVALID, 0);
        reg_rd(5'h17, d); chk("cs_status", d, 8'h06);
        chk("cs_intrq_clr", bus.INTRQ, 0);
        reg_rd(5'h17, d); chk("cs_status_clr", d, 8'h00);

        // ---- abort in REQ; TC write while busy ignored
        set_tc(16'd5);
        reg_wr(5'h01, 8'h01);
        wait_dreq("ab_dreq");
        reg_wr(5'h13, 8'h77);
        reg_wr(5'h01, 8'h00);
        chk("ab_dreq_high", bus.DREQ_, 1);
        reg_rd(5'h13, d); chk("ab_tc_lo", d, 5);
        reg_rd(5'h12, d); chk("ab_tc_hi", d, 0);
        reg_rd(5'h17, d); chk("ab_status", d, 0);

        // ---- reset during XFER
        ph_push(8'($urandom));
        ph_push(8'($urandom));
        set_tc(16'd2);
        reg_wr(5'h01, 8'h03);
        wait_dreq("rs_dreq");
        bus.DACK = 1'b1; bus.RE = 1'b1;
        tick(); tick();
        chk("rs_doe_pre", bus.DOE, 1);
        RESET = 1'b1;
        #1;
        chk("rs_dreq", bus.DREQ_, 1);
        chk("rs_doe", bus.DOE, 0);
        chk("rs_fifo", bus.PH_RVALID, 0);
        q.delete();
        bus.RE = 1'b0; bus.DACK = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        reg_rd(5'h12, d); chk("rs_tc_hi", d, 0);
        reg_rd(5'h13, d); chk("rs_tc_lo", d, 0);
        reg_rd(5'h01, d); chk("rs_ctrl", d, 0);

        // ---- AR wrap
        bus_wr(1'b0, 8'h1F);
        bus_wr(1'b1, 8'($urandom));
        bus_rd(1'b0, d, oe);
        chk("ar_wrap", d, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
